bit_decoder: RTL and testbench

BIT_DECODER -- requirements
Module: bit_decoder

---
 rtl/bit_decoder_pkg.sv | 35 +++
 rtl/bit_mask_gen.sv | 31 +++
 rtl/bit_decoder.sv | 98 +++++++++
 tb/tb_bit_decoder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_decoder_pkg.sv
// Shared op codes, widths and payload types for the bit decoder and ff1/fl1 finder logic.
package bit_decoder_pkg;

    localparam int unsigned INDEX_W = 6;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned POS_W   = 5;

    typedef enum logic [2:0] {
        OP_ONEHOT    = 3'b000,
        OP_SET       = 3'b001,
        OP_CLEAR     = 3'b010,
        OP_TOGGLE    = 3'b011,
        OP_MASK_LOW  = 3'b100,
        OP_MASK_HIGH = 3'b101,
        OP_ISOLATE   = 3'b110,
        OP_RSVD      = 3'b111
    } bitOpT;

    typedef struct packed {
        bitOpT               op;
        logic [INDEX_W-1:0]  index;
        logic [DATA_W-1:0]   operand;
    } bitReqT;

    // ff1 encoding of a word: lowest set bit position + 1, or 0 when the word is empty.
    function automatic logic [INDEX_W-1:0] ff1Index(input logic [DATA_W-1:0] word);
        ff1Index = '0;
        for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
            if (word[i]) begin
                ff1Index = INDEX_W'(i + 1);
            end
        end
    endfunction

endpackage

// File: rtl/bit_mask_gen.sv
// Turns a 1-based bit index into its one-hot, low mask and high mask words.
module bit_mask_gen
    import bit_decoder_pkg::*;
(
    input  logic [INDEX_W-1:0] index,
    output logic [DATA_W-1:0]  oh,
    output logic [DATA_W-1:0]  mask_low,
    output logic [DATA_W-1:0]  mask_high,
    output logic               index_bad
);

    localparam logic [DATA_W-1:0] ALL_ONES = '1;
    localparam logic [POS_W-1:0]  TOP_POS  = POS_W'(DATA_W - 1);

    logic [POS_W-1:0] bitPos;

    // Index 0 and out-of-range indices produce empty masks.
    always_comb begin
        oh        = '0;
        mask_low  = '0;
        mask_high = '0;
        index_bad = (index > INDEX_W'(DATA_W));
        bitPos    = POS_W'(index - INDEX_W'(1));
        if (!index_bad && (index != '0)) begin
            oh        = DATA_W'(1) << bitPos;
            mask_low  = ALL_ONES >> (TOP_POS - bitPos);
            mask_high = ALL_ONES << bitPos;
        end
    end

endmodule

// File: rtl/bit_decoder.sv
// Two-stage bit-manipulation pipeline: stage 1 holds the request, stage 2 the result.
module bit_decoder
    import bit_decoder_pkg::*;
#(
    parameter int unsigned INVALID_PASS = 1
)
(
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INDEX_W-1:0]  in_index,
    input  logic [DATA_W-1:0]   in_operand,
    input  logic [2:0]          in_op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_result,
    output logic                out_invalid
);

    logic               s1Valid;
    bitReqT             s1Req;
    bitReqT             newReq;
    logic               accept;
    logic               advance;
    logic [DATA_W-1:0]  maskOh;
    logic [DATA_W-1:0]  maskLow;
    logic [DATA_W-1:0]  maskHigh;
    logic               maskBad;
    logic [DATA_W-1:0]  calcResult;
    logic               calcInvalid;

    // Room exists whenever either stage is empty or the output drains this edge.
    assign in_ready = ~s1Valid | ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign advance  = s1Valid & (~out_valid | out_ready);

    assign newReq.op      = bitOpT'(in_op);
    assign newReq.index   = in_index;
    assign newReq.operand = in_operand;

    bit_mask_gen uMaskGen (
        .index     (s1Req.index),
        .oh        (maskOh),
        .mask_low  (maskLow),
        .mask_high (maskHigh),
        .index_bad (maskBad)
    );

    // Apply the selected operation to the stage-1 request.
    always_comb begin
        calcInvalid = maskBad || (s1Req.op == OP_RSVD);
        calcResult  = '0;
        if (calcInvalid) begin
            calcResult = (INVALID_PASS != 0) ? s1Req.operand : '0;
        end else begin
            case (s1Req.op)
                OP_ONEHOT:    calcResult = maskOh;
                OP_SET:       calcResult = s1Req.operand | maskOh;
                OP_CLEAR:     calcResult = s1Req.operand & ~maskOh;
                OP_TOGGLE:    calcResult = s1Req.operand ^ maskOh;
                OP_MASK_LOW:  calcResult = maskLow;
                OP_MASK_HIGH: calcResult = maskHigh;
                OP_ISOLATE:   calcResult = s1Req.operand & maskOh;
                default:      calcResult = '0;
            endcase
        end
    end

    // Stage 1: capture an accepted request; a same-edge accept replaces the one moving on.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1Valid <= 1'b0;
            s1Req   <= '0;
        end else if (accept) begin
            s1Valid <= 1'b1;
            s1Req   <= newReq;
        end else if (advance) begin
            s1Valid <= 1'b0;
        end
    end

    // Stage 2: register the result and hold it until the consumer takes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_invalid <= 1'b0;
        end else if (advance) begin
            out_valid   <= 1'b1;
            out_result  <= calcResult;
            out_invalid <= calcInvalid;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bit_decoder.sv
// Directed checks of bit_decoder with both INVALID_PASS settings side by side.
module tb_bit_decoder;
    import bit_decoder_pkg::*;

    typedef struct {
        logic [31:0] expPass;
        logic [31:0] expZero;
        logic        expInv;
        logic [5:0]  idx;
        bit          roundTrip;
    } expT;

    logic        clock;
    logic        reset;
    logic        inValid;
    logic [5:0]  inIndex;
    logic [31:0] inOperand;
    logic [2:0]  inOp;
    logic        outReady;
    logic        inReadyP, outValidP, outInvalidP;
    logic [31:0] outResultP;
    logic        inReadyZ, outValidZ, outInvalidZ;
    logic [31:0] outResultZ;

    int  assertCount = 0;
    int  failCount   = 0;
    expT expQ[$];
    bit  streamDone;

    logic        prevStall;
    logic [31:0] prevResult;
    logic        prevInvalid;

    bit_decoder #(.INVALID_PASS(1)) dutPass (
        .clock(clock), .reset(reset), .in_valid(inValid), .in_ready(inReadyP),
        .in_index(inIndex), .in_operand(inOperand), .in_op(inOp),
        .out_valid(outValidP), .out_ready(outReady),
        .out_result(outResultP), .out_invalid(outInvalidP)
    );

    bit_decoder #(.INVALID_PASS(0)) dutZero (
        .clock(clock), .reset(reset), .in_valid(inValid), .in_ready(inReadyZ),
        .in_index(inIndex), .in_operand(inOperand), .in_op(inOp),
        .out_valid(outValidZ), .out_ready(outReady),
        .out_result(outResultZ), .out_invalid(outInvalidZ)
    );

    always #5 clock = ~clock;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] firstOne(input logic [31:0] w);
        for (int i = 0; i < 32; i++) begin
            if (w[i]) return 32'(i + 1);
        end
        return 32'd0;
    endfunction

    // Entered and left just after a rising edge; holds the request until accepted.
    task automatic sendReq(input logic [2:0] op, input logic [5:0] idx, input logic [31:0] opnd,
                           input logic [31:0] expPass, input logic [31:0] expZero,
                           input logic expInv, input bit roundTrip);
        int   waitCycles = 0;
        logic taken = 1'b0;
        expQ.push_back('{expPass, expZero, expInv, idx, roundTrip});
        inValid   = 1'b1;
        inOp      = op;
        inIndex   = idx;
        inOperand = opnd;
        while (!taken) begin
            @(negedge clock);
            taken = inReadyP;
            @(posedge clock);
            #1;
            waitCycles++;
            if (!taken && waitCycles > 500) begin
                checkEq("acceptTimeout", 32'd0, 32'd1);
                break;
            end
        end
        inValid = 1'b0;
    endtask

    task automatic sendValid(input logic [2:0] op, input logic [5:0] idx,
                             input logic [31:0] opnd, input logic [31:0] exp);
        sendReq(op, idx, opnd, exp, exp, 1'b0, 1'b0);
    endtask

    task automatic waitDrain();
        int cycles = 0;
        while (expQ.size() != 0 && cycles < 500) begin
            @(posedge clock);
            #1;
            cycles++;
        end
        if (expQ.size() != 0) checkEq("drainTimeout", 32'(expQ.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: compare each result as it is handed over, and hold stability while stalled.
    always @(negedge clock) begin
        expT e;
        if (reset) begin
            prevStall <= 1'b0;
        end else begin
            if (prevStall) begin
                checkEq("stallValid", 32'(outValidP), 32'd1);
                checkEq("stallResult", outResultP, prevResult);
                checkEq("stallInvalid", 32'(outInvalidP), 32'(prevInvalid));
            end
            if (outValidP && outReady) begin
                if (expQ.size() == 0) begin
                    checkEq("unexpectedOut", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkEq("resultPass", outResultP, e.expPass);
                    checkEq("invalidPass", 32'(outInvalidP), 32'(e.expInv));
                    checkEq("validZero", 32'(outValidZ), 32'd1);
                    checkEq("resultZero", outResultZ, e.expZero);
                    checkEq("invalidZero", 32'(outInvalidZ), 32'(e.expInv));
                    if (e.roundTrip) checkEq("ff1RoundTrip", firstOne(outResultP), 32'(e.idx));
                end
            end
            prevStall   <= outValidP && !outReady;
            prevResult  <= outResultP;
            prevInvalid <= outInvalidP;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clock      = 1'b0;
        reset      = 1'b1;
        inValid    = 1'b0;
        inIndex    = '0;
        inOperand  = '0;
        inOp       = '0;
        outReady   = 1'b0;
        streamDone = 1'b0;
        prevStall  = 1'b0;
        prevResult = '0;
        prevInvalid = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkEq("rstOutValid", 32'(outValidP), 32'd0);
        checkEq("rstOutResult", outResultP, 32'd0);
        checkEq("rstOutInvalid", 32'(outInvalidP), 32'd0);
        checkEq("rstInReady", 32'(inReadyP), 32'd1);
        @(posedge clock);
        #1;

        // Back-to-back ONEHOT with fixed two-edge latency.
        outReady = 1'b1;
        fork
            begin
                sendValid(OP_ONEHOT, 6'd1, 32'h0, 32'h0000_0001);
                sendValid(OP_ONEHOT, 6'd32, 32'h0, 32'h8000_0000);
            end
            begin
                @(negedge clock);
                @(negedge clock);
                checkEq("latNotYet", 32'(outValidP), 32'd0);
                @(negedge clock);
                checkEq("latFirst", 32'(outValidP), 32'd1);
                @(negedge clock);
                checkEq("latSecond", 32'(outValidP), 32'd1);
            end
        join
        waitDrain();

        // Directed operation vectors including index 0 and index 32 boundaries.
        sendValid(OP_SET,       6'd1,  32'h0000_00F0, 32'h0000_00F1);
        sendValid(OP_CLEAR,     6'd5,  32'h0000_00F0, 32'h0000_00E0);
        sendValid(OP_TOGGLE,    6'd16, 32'h0000_0000, 32'h0000_8000);
        sendValid(OP_MASK_LOW,  6'd8,  32'h0,         32'h0000_00FF);
        sendValid(OP_MASK_HIGH, 6'd8,  32'h0,         32'hFFFF_FF80);
        sendValid(OP_MASK_LOW,  6'd0,  32'hFFFF_FFFF, 32'h0);
        sendValid(OP_MASK_HIGH, 6'd0,  32'hFFFF_FFFF, 32'h0);
        sendValid(OP_ONEHOT,    6'd0,  32'hFFFF_FFFF, 32'h0);
        sendValid(OP_ISOLATE,   6'd0,  32'hFFFF_FFFF, 32'h0);
        sendValid(OP_SET,       6'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF);
        sendValid(OP_CLEAR,     6'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF);
        sendValid(OP_TOGGLE,    6'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF);
        sendValid(OP_MASK_LOW,  6'd32, 32'h0,         32'hFFFF_FFFF);
        sendValid(OP_MASK_HIGH, 6'd32, 32'h0,         32'h8000_0000);
        sendValid(OP_ISOLATE,   6'd5,  32'h0000_00F0, 32'h0000_0010);
        sendValid(OP_CLEAR,     6'd32, 32'hFFFF_FFFF, 32'h7FFF_FFFF);

        // Invalid index or reserved op.
        sendReq(OP_SET,    6'd40, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b1, 1'b0);
        sendReq(3'b111,    6'd3,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0, 1'b1, 1'b0);
        sendReq(OP_ONEHOT, 6'd63, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0, 1'b1, 1'b0);
        sendReq(OP_MASK_LOW, 6'd33, 32'h0000_0042, 32'h0000_0042, 32'h0, 1'b1, 1'b0);
        sendReq(3'b111,    6'd0,  32'hCAFE_F00D, 32'hCAFE_F00D, 32'h0, 1'b1, 1'b0);
        waitDrain();

        // ONEHOT round trip through an ff1 finder for every legal index.
        for (int i = 1; i <= 32; i++) begin
            sendReq(OP_ONEHOT, 6'(i), 32'h0, 32'd1 << (i - 1), 32'd1 << (i - 1), 1'b0, 1'b1);
        end
        waitDrain();

        // Streaming under backpressure: stall 5 cycles, then random consumer readiness.
        outReady   = 1'b0;
        streamDone = 1'b0;
        fork
            begin
                sendValid(OP_SET,       6'd1,  32'h0000_0000, 32'h0000_0001);
                sendValid(OP_SET,       6'd2,  32'h0000_0001, 32'h0000_0003);
                sendValid(OP_CLEAR,     6'd32, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
                sendValid(OP_TOGGLE,    6'd8,  32'h0000_00FF, 32'h0000_007F);
                sendValid(OP_ISOLATE,   6'd5,  32'h0000_00F0, 32'h0000_0010);
                sendValid(OP_MASK_LOW,  6'd16, 32'h0,         32'h0000_FFFF);
                sendValid(OP_MASK_HIGH, 6'd32, 32'h0,         32'h8000_0000);
                sendValid(OP_ONEHOT,    6'd20, 32'h0,         32'h0008_0000);
                streamDone = 1'b1;
            end
            begin
                repeat (5) @(posedge clock);
                @(negedge clock);
                checkEq("fullInReady", 32'(inReadyP), 32'd0);
                checkEq("fullOutValid", 32'(outValidP), 32'd1);
                @(posedge clock);
                #1;
                while (!streamDone) begin
                    outReady = 1'($urandom_range(0, 1));
                    @(posedge clock);
                    #1;
                end
            end
        join
        outReady = 1'b1;
        waitDrain();

        // Reset with two requests in flight discards both.
        outReady = 1'b0;
        sendValid(OP_ONEHOT, 6'd3, 32'h0, 32'h0000_0004);
        sendValid(OP_ONEHOT, 6'd4, 32'h0, 32'h0000_0008);
        reset = 1'b1;
        expQ.delete();
        @(posedge clock);
        #1;
        reset    = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkEq("flushNoValid", 32'(outValidP), 32'd0);
        end
        checkEq("flushReadyPass", 32'(inReadyP), 32'd1);
        checkEq("flushReadyZero", 32'(inReadyZ), 32'd1);
        @(posedge clock);
        #1;
        sendValid(OP_TOGGLE, 6'd1, 32'h0000_000F, 32'h0000_000E);
        waitDrain();

        checkEq("queueDrained", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
